// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the add_slice_sequencer block.
package add_seq_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Beat counter width for a given beat count (at least one bit).
    function automatic int unsigned beat_width(input int unsigned nbeats);
        return (nbeats > 1) ? $clog2(nbeats) : 1;
    endfunction

endpackage

// File: rtl/add4_slice.sv
// Combinational 4-bit ripple-carry adder slice built from 1-bit full adders.
module add4_slice
    import add_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               ci,
    output logic [SLICE_W-1:0] s,
    output logic               co
);

    logic [SLICE_W:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[SLICE_W];

endmodule

// File: rtl/add_slice_sequencer.sv
// Two-requester round-robin sequencer driving one shared 4-bit adder slice.
// Optional macro SUBTRACT_EN adds sub0/sub1 inputs for a-b operation.
module add_slice_sequencer
    import add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             cin0,
`ifdef SUBTRACT_EN
    input  logic             sub0,
    input  logic             sub1,
`endif
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             cin1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NBEATS = WIDTH / SLICE_W;
    localparam int unsigned BEAT_W = beat_width(NBEATS);

    seq_state_e         state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               sub_q, sub_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic [WIDTH-1:0]   shadow_q, shadow_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               done_id_q, done_id_d;

    logic               win1_c;
    logic               sub_sel_c;
    logic [SLICE_W-1:0] slice_a_c, slice_b_c, slice_s_c;
    logic               slice_co_c;
    logic [WIDTH-1:0]   res_c;

    // On a tie the requester that did not win last time gets the slot.
    assign win1_c = req1 & (~req0 | ~last_q);

`ifdef SUBTRACT_EN
    assign sub_sel_c = win1_c ? sub1 : sub0;
`else
    assign sub_sel_c = 1'b0;
`endif

    assign slice_a_c = a_q[SLICE_W*beat_q +: SLICE_W];
    assign slice_b_c = b_q[SLICE_W*beat_q +: SLICE_W] ^ {SLICE_W{sub_q}};

    add4_slice u_slice (
        .a  (slice_a_c),
        .b  (slice_b_c),
        .ci (carry_q),
        .s  (slice_s_c),
        .co (slice_co_c)
    );

    always_comb begin
        res_c = shadow_q;
        res_c[SLICE_W*beat_q +: SLICE_W] = slice_s_c;
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        carry_d   = carry_q;
        a_d       = a_q;
        b_d       = b_q;
        sub_d     = sub_q;
        owner_d   = owner_q;
        last_d    = last_q;
        shadow_d  = shadow_q;
        sum_d     = sum_q;
        cout_d    = cout_q;
        done_id_d = done_id_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt0    = ~win1_c;
                    gnt1    = win1_c;
                    a_d     = win1_c ? a1 : a0;
                    b_d     = win1_c ? b1 : b0;
                    sub_d   = sub_sel_c;
                    carry_d = sub_sel_c ? 1'b1 : (win1_c ? cin1 : cin0);
                    owner_d = win1_c;
                    last_d  = win1_c;
                    beat_d  = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                shadow_d = res_c;
                carry_d  = slice_co_c;
                beat_d   = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(NBEATS - 1)) begin
                    sum_d     = res_c;
                    cout_d    = slice_co_c;
                    done_id_d = owner_q;
                    beat_d    = '0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            beat_q    <= '0;
            carry_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sub_q     <= 1'b0;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            shadow_q  <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_id_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            carry_q   <= carry_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sub_q     <= sub_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            shadow_q  <= shadow_d;
            sum_q     <= sum_d;
            cout_q    <= cout_d;
            done_id_q <= done_id_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign done_id = done_id_q;
    assign sum     = sum_q;
    assign cout    = cout_q;

endmodule

// File: tb/tb_add_slice_sequencer.sv
// Directed, table-driven bench for add_slice_sequencer (WIDTH=16).
module tb_add_slice_sequencer;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NBEATS = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, cin0, cin1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             sub0, sub1;
    logic             gnt0, gnt1, busy, done, done_id, cout;
    logic [WIDTH-1:0] sum;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    add_slice_sequencer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req0    (req0),
        .a0      (a0),
        .b0      (b0),
        .cin0    (cin0),
`ifdef SUBTRACT_EN
        .sub0    (sub0),
        .sub1    (sub1),
`endif
        .req1    (req1),
        .a1      (a1),
        .b1      (b1),
        .cin1    (cin1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .sum     (sum),
        .cout    (cout)
    );

    typedef struct {
        logic             req0, req1;
        logic [WIDTH-1:0] a0, b0, a1, b1;
        logic             cin0, cin1, sub0, sub1;
        logic             exp_id;
        logic [WIDTH-1:0] exp_sum;
        logic             exp_cout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        req0 = v.req0; req1 = v.req1;
        a0 = v.a0; b0 = v.b0; cin0 = v.cin0; sub0 = v.sub0;
        a1 = v.a1; b1 = v.b1; cin1 = v.cin1; sub1 = v.sub1;
    endtask

    // Called just after inputs change at a negedge; returns with a grant visible.
    task automatic wait_gnt(input string name, output logic ok);
        int n = 0;
        #1;
        while (!(gnt0 | gnt1) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        ok = gnt0 | gnt1;
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no grant within 20 cycles", name);
        end
    endtask

    // Counts negedges after the acceptance edge until done; returns count.
    task automatic wait_done(input string name, output int k);
        k = 0;
        while (k < 12) begin
            @(negedge clk);
            k++;
            if (done) break;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no done within 12 cycles", name);
        end
    endtask

    task automatic run_vec(input string name, input vec_t v);
        logic ok;
        int   k;
        drive(v);
        wait_gnt(name, ok);
        if (ok) begin
            chk({name, "_gnt0"}, 32'(gnt0), 32'(!v.exp_id));
            chk({name, "_gnt1"}, 32'(gnt1), 32'(v.exp_id));
            @(posedge clk);
            #1;
            req0 = 1'b0;
            req1 = 1'b0;
            wait_done(name, k);
            chk({name, "_lat"},  32'(k),       32'(NBEATS + 1));
            chk({name, "_sum"},  32'(sum),     32'(v.exp_sum));
            chk({name, "_cout"}, 32'(cout),    32'(v.exp_cout));
            chk({name, "_id"},   32'(done_id), 32'(v.exp_id));
            @(negedge clk);
            chk({name, "_hold"}, 32'({done, sum}), 32'({1'b0, v.exp_sum}));
        end
    endtask

    function automatic vec_t mk(input logic r0, input logic r1,
                                input logic [WIDTH-1:0] xa0, input logic [WIDTH-1:0] xb0, input logic c0,
                                input logic [WIDTH-1:0] xa1, input logic [WIDTH-1:0] xb1, input logic c1,
                                input logic id, input logic [WIDTH-1:0] s, input logic co);
        vec_t v;
        v.req0 = r0; v.req1 = r1;
        v.a0 = xa0; v.b0 = xb0; v.cin0 = c0;
        v.a1 = xa1; v.b1 = xb1; v.cin1 = c1;
        v.sub0 = 1'b0; v.sub1 = 1'b0;
        v.exp_id = id; v.exp_sum = s; v.exp_cout = co;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        logic ok;
        int   k;
        int   g_prev;
        vec_t v;
        logic [WIDTH-1:0] tie_sum[2];
        logic             tie_cout[2];

        vecs.push_back(mk(1, 0, 16'h1234, 16'h4321, 0, 16'h0000, 16'h0000, 0, 0, 16'h5555, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0, 16'hFFFF, 16'h0001, 0, 1, 16'h0000, 1));
        vecs.push_back(mk(1, 0, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 16'h0000, 0, 0, 16'hFFFF, 1));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0, 16'h00FF, 16'h0001, 1, 1, 16'h0101, 0));
        vecs.push_back(mk(1, 1, 16'h8000, 16'h8000, 0, 16'h1111, 16'h1111, 0, 0, 16'h0000, 1));
        vecs.push_back(mk(1, 1, 16'h2222, 16'h2222, 0, 16'h0F0F, 16'h00F1, 0, 1, 16'h1000, 0));
        vecs.push_back(mk(0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 1, 1, 16'h0001, 0));
`ifdef SUBTRACT_EN
        v = mk(1, 0, 16'h0005, 16'h0007, 0, 16'h0000, 16'h0000, 0, 0, 16'hFFFE, 0);
        v.sub0 = 1'b1;
        vecs.push_back(v);
        v = mk(0, 1, 16'h0000, 16'h0000, 0, 16'h1000, 16'h0001, 0, 1, 16'h0FFF, 1);
        v.sub1 = 1'b1;
        vecs.push_back(v);
`endif

        rst = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(negedge clk);
        chk("rst_outs", 32'({gnt0, gnt1, busy, done, done_id, cout}), 32'(0));
        chk("rst_sum", 32'(sum), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", 32'({busy, done}), 32'(0));

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Both held continuously after reset: expect 0,1,0,1 at one op per NBEATS+2.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tie_sum[0] = 16'h3333; tie_cout[0] = 1'b0;
        tie_sum[1] = 16'h0001; tie_cout[1] = 1'b1;
        drive(mk(1, 1, 16'h1111, 16'h2222, 0, 16'h8000, 16'h8000, 1, 0, 0, 0));
        g_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_gnt($sformatf("tie%0d", i), ok);
            if (!ok) break;
            chk($sformatf("tie%0d_ovl", i), 32'(gnt0 & gnt1), 32'(0));
            chk($sformatf("tie%0d_gnt1", i), 32'(gnt1), 32'(i % 2));
            if (i > 0) chk($sformatf("tie%0d_gap", i), 32'(cyc - g_prev), 32'(NBEATS + 2));
            g_prev = cyc;
            @(posedge clk);
            wait_done($sformatf("tie%0d", i), k);
            chk($sformatf("tie%0d_id", i), 32'(done_id), 32'(i % 2));
            chk($sformatf("tie%0d_sum", i), 32'({cout, sum}), 32'({tie_cout[i % 2], tie_sum[i % 2]}));
            @(negedge clk);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (NBEATS + 3) @(negedge clk);

        // Reset in beat 2 of a requester-0 op: no done, regs cleared, req0 wins next tie.
        drive(mk(1, 0, 16'h0F00, 16'h0100, 0, 0, 0, 0, 0, 0, 0));
        wait_gnt("abort", ok);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_pre", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_outs", 32'({busy, done, done_id, cout}), 32'(0));
        chk("abort_sum", 32'(sum), 32'(0));
        k = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) k++;
        end
        chk("abort_nodone", 32'(k), 32'(0));
        run_vec("post_abort", mk(1, 1, 16'h00AA, 16'h0055, 0, 16'h1111, 16'h1111, 0, 0, 16'h00FF, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
